bias_rd_ctrl: RTL and testbench

- Read sequencer for the bias ROM datapath.
- Per layer, it walks the bias ROM from a configured base address through a configured number of bias groups. It drives the ROM read address and the output-gate enable, and presents each group to the convolution engine under a valid/request handshake.
- It signals layer completion back to the top-level layer FSM.
- Sits between the top-level layer FSM, the bias memory top, and the conv accumulator.

---
 rtl/bias_rd_ctrl.sv | 139 +++++++++++++
 tb/tb_bias_rd_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_rd_ctrl.sv
// Bias ROM read sequencer: walks base..base+count-1 once per layer and presents each
// group to the convolution engine under a valid/request handshake.
module bias_rd_ctrl #(
  parameter int RD_ADDR_DEPTH  = 9,
  parameter int ROM_RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [2:0]               current_state,
  input  logic [RD_ADDR_DEPTH-1:0] cfg_base_addr,
  input  logic [RD_ADDR_DEPTH-1:0] cfg_group_cnt,
  input  logic                     bias_req,
  output logic [RD_ADDR_DEPTH-1:0] addr_rd,
  output logic                     bias_out_valid,
  output logic                     BiasMem_valid_out,
  output logic                     state_rst,
  output logic                     busy
);

  localparam int LAT_W = (ROM_RD_LATENCY > 1) ? $clog2(ROM_RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0]         LAT_LAST = LAT_W'(ROM_RD_LATENCY - 1);
  localparam logic [LAT_W-1:0]         LAT_ONE  = LAT_W'(1);
  localparam logic [RD_ADDR_DEPTH-1:0] ONE      = RD_ADDR_DEPTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [2:0]               prev_state;
  logic [RD_ADDR_DEPTH-1:0] base_q, base_nxt;
  logic [RD_ADDR_DEPTH-1:0] cnt_q, cnt_nxt;
  logic [RD_ADDR_DEPTH-1:0] idx_q, idx_nxt;
  logic [RD_ADDR_DEPTH-1:0] addr_nxt;
  logic [LAT_W-1:0]         lat_q, lat_nxt;
  logic                     start_evt;
  logic                     abort;

  // A layer starts on any change into a nonzero code; holding a code never retriggers.
  assign start_evt = (current_state != 3'd0) && (current_state != prev_state);
  assign abort     = (current_state == 3'd0);

  // NOTE: every signal gets its default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    base_nxt  = base_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    addr_nxt  = addr_rd;
    lat_nxt   = lat_q;

    if (start_evt) begin
      // A start wins over bias_req and aborts any layer still in flight.
      base_nxt = cfg_base_addr;
      cnt_nxt  = cfg_group_cnt;
      idx_nxt  = '0;
      lat_nxt  = '0;
      if (cfg_group_cnt == '0) begin
        state_nxt = S_DONE;
        addr_nxt  = '0;
      end else begin
        state_nxt = S_FETCH;
        addr_nxt  = cfg_base_addr;
      end
    end else begin
      case (state)
        S_IDLE: begin
          addr_nxt = '0;
        end
        S_FETCH: begin
          if (abort) begin
            state_nxt = S_IDLE;
            addr_nxt  = '0;
          end else if (lat_q == LAT_LAST) begin
            state_nxt = S_HOLD;
          end else begin
            lat_nxt = lat_q + LAT_ONE;
          end
        end
        S_HOLD: begin
          if (abort) begin
            state_nxt = S_IDLE;
            addr_nxt  = '0;
          end else if (bias_req) begin
            if (idx_q == cnt_q - ONE) begin
              state_nxt = S_DONE;
              addr_nxt  = '0;
            end else begin
              state_nxt = S_FETCH;
              idx_nxt   = idx_q + ONE;
              addr_nxt  = base_q + idx_q + ONE;
              lat_nxt   = '0;
            end
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
          addr_nxt  = '0;
        end
        default: begin
          state_nxt = S_IDLE;
          addr_nxt  = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      prev_state <= 3'd0;
      base_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      addr_rd    <= '0;
    end else begin
      state      <= state_nxt;
      prev_state <= current_state;
      base_q     <= base_nxt;
      cnt_q      <= cnt_nxt;
      idx_q      <= idx_nxt;
      lat_q      <= lat_nxt;
      addr_rd    <= addr_nxt;
    end
  end

  // Handshake outputs decode straight from the state register.
  assign bias_out_valid    = (state == S_FETCH) || (state == S_HOLD);
  assign BiasMem_valid_out = (state == S_HOLD);
  assign state_rst         = (state == S_DONE);
  assign busy              = (state != S_IDLE);

endmodule

// File: tb/tb_bias_rd_ctrl.sv
// Scoreboard bench for bias_rd_ctrl: directed scenarios plus randomized layers, with a
// monitor that matches every consumed group and every layer-done pulse against a queue.
module tb_bias_rd_ctrl;

  localparam int AW = 9;
  typedef logic [AW-1:0] addr_t;

  typedef struct {
    bit    is_done;
    addr_t addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] current_state;
  addr_t      cfg_base_addr;
  addr_t      cfg_group_cnt;
  logic       bias_req;
  addr_t      addr_rd;
  logic       bias_out_valid;
  logic       BiasMem_valid_out;
  logic       state_rst;
  logic       busy;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] tb_prev;

  addr_t      wrap_a[4] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
  addr_t      r_base;
  logic [2:0] r_cs;
  int         r_cnt, r_abort, r_cons;
  bit         r_fin, r_will;

  always #5 clk = ~clk;

  bias_rd_ctrl #(.RD_ADDR_DEPTH(AW), .ROM_RD_LATENCY(1)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .current_state    (current_state),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_group_cnt    (cfg_group_cnt),
    .bias_req         (bias_req),
    .addr_rd          (addr_rd),
    .bias_out_valid   (bias_out_valid),
    .BiasMem_valid_out(BiasMem_valid_out),
    .state_rst        (state_rst),
    .busy             (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string name, input addr_t a, input logic bov,
                            input logic vout, input logic srst, input logic bsy);
    check(name, 32'({addr_rd, bias_out_valid, BiasMem_valid_out, state_rst, busy}),
          32'({a, bov, vout, srst, bsy}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected group addresses: base + i wrapped to the address width.
  function automatic void push_groups(input addr_t base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.is_done = 1'b0;
      e.addr    = addr_t'((int'(base) + i) % (1 << AW));
      sb_q.push_back(e);
    end
  endfunction

  function automatic void push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.addr    = '0;
    sb_q.push_back(e);
  endfunction

  // Reference copy of the previous layer code, used to tell a start from a consume.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) tb_prev <= 3'd0;
    else       tb_prev <= current_state;
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (!busy)
        check("idle_outputs", 32'({addr_rd, bias_out_valid, BiasMem_valid_out, state_rst}), 32'd0);
      if (state_rst) begin
        check("done_outputs", 32'({addr_rd, bias_out_valid, BiasMem_valid_out}), 32'd0);
        check("sb_done_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("sb_done_kind", 32'(mon_e.is_done), 32'd1);
        end
      end
      if (BiasMem_valid_out) begin
        check("hold_gate", 32'(bias_out_valid), 32'd1);
        if (bias_req && current_state != 3'd0 && current_state == tb_prev) begin
          check("sb_group_pending", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("sb_group_kind", 32'(mon_e.is_done), 32'd0);
            check("sb_group_addr", 32'(addr_rd), 32'(mon_e.addr));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn          = 1'b0;
    current_state = 3'd0;
    cfg_base_addr = '0;
    cfg_group_cnt = '0;
    bias_req      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_state", 9'h000, 0, 0, 0, 0);
    rstn = 1'b1;
    step();

    // Basic three-group layer, config changes after the start are ignored.
    cfg_base_addr = 9'h010; cfg_group_cnt = 9'd3; current_state = 3'd1;
    push_groups(9'h010, 3); push_done();
    step(); expect_out("basic_fetch0", 9'h010, 1, 0, 0, 1);
    cfg_base_addr = 9'h155; cfg_group_cnt = 9'd7;
    step(); expect_out("basic_hold0", 9'h010, 1, 1, 0, 1);
    bias_req = 1'b1;
    step(); expect_out("basic_fetch1", 9'h011, 1, 0, 0, 1);
    step(); expect_out("basic_hold1", 9'h011, 1, 1, 0, 1);
    step(); expect_out("basic_fetch2", 9'h012, 1, 0, 0, 1);
    step(); expect_out("basic_hold2", 9'h012, 1, 1, 0, 1);
    step(); expect_out("basic_done", 9'h000, 0, 0, 1, 1);
    bias_req = 1'b0;
    step(); expect_out("basic_idle", 9'h000, 0, 0, 0, 0);
    repeat (3) step();
    expect_out("no_retrigger", 9'h000, 0, 0, 0, 0);

    // Backpressure in the first HOLD.
    cfg_base_addr = 9'h010; cfg_group_cnt = 9'd2; current_state = 3'd2;
    push_groups(9'h010, 2); push_done();
    step(); expect_out("bp_fetch0", 9'h010, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(); expect_out("bp_hold0", 9'h010, 1, 1, 0, 1);
    end
    bias_req = 1'b1;
    step(); expect_out("bp_fetch1", 9'h011, 1, 0, 0, 1);
    step(); expect_out("bp_hold1", 9'h011, 1, 1, 0, 1);
    step(); expect_out("bp_done", 9'h000, 0, 0, 1, 1);
    bias_req = 1'b0;
    step(); expect_out("bp_idle", 9'h000, 0, 0, 0, 0);

    // Address wrap with bias_req held high: one group every two cycles.
    cfg_base_addr = 9'h1FE; cfg_group_cnt = 9'd4; current_state = 3'd3; bias_req = 1'b1;
    push_groups(9'h1FE, 4); push_done();
    for (int i = 0; i < 4; i++) begin
      step(); expect_out("wrap_fetch", wrap_a[i], 1, 0, 0, 1);
      step(); expect_out("wrap_hold", wrap_a[i], 1, 1, 0, 1);
    end
    step(); expect_out("wrap_done", 9'h000, 0, 0, 1, 1);
    bias_req = 1'b0;
    step(); expect_out("wrap_idle", 9'h000, 0, 0, 0, 0);

    // Zero-count layer goes straight to the done pulse.
    cfg_base_addr = 9'h0AB; cfg_group_cnt = 9'd0; current_state = 3'd4;
    push_done();
    step(); expect_out("zero_done", 9'h000, 0, 0, 1, 1);
    step(); expect_out("zero_idle", 9'h000, 0, 0, 0, 0);

    // Abort in the second HOLD.
    cfg_base_addr = 9'h020; cfg_group_cnt = 9'd4; current_state = 3'd5;
    push_groups(9'h020, 1);
    step(); expect_out("abort_fetch0", 9'h020, 1, 0, 0, 1);
    step(); expect_out("abort_hold0", 9'h020, 1, 1, 0, 1);
    bias_req = 1'b1;
    step(); expect_out("abort_fetch1", 9'h021, 1, 0, 0, 1);
    bias_req = 1'b0;
    step(); expect_out("abort_hold1", 9'h021, 1, 1, 0, 1);
    current_state = 3'd0;
    step(); expect_out("abort_idle", 9'h000, 0, 0, 0, 0);
    step(); expect_out("abort_stay", 9'h000, 0, 0, 0, 0);

    // Restart during HOLD together with bias_req.
    cfg_base_addr = 9'h040; cfg_group_cnt = 9'd3; current_state = 3'd1;
    step(); expect_out("rs_fetch_old", 9'h040, 1, 0, 0, 1);
    step(); expect_out("rs_hold_old", 9'h040, 1, 1, 0, 1);
    cfg_base_addr = 9'h080; cfg_group_cnt = 9'd2; current_state = 3'd2; bias_req = 1'b1;
    push_groups(9'h080, 2); push_done();
    step(); expect_out("rs_fetch_new", 9'h080, 1, 0, 0, 1);
    cfg_base_addr = 9'h1C3; cfg_group_cnt = 9'd9;
    step(); expect_out("rs_hold0", 9'h080, 1, 1, 0, 1);
    step(); expect_out("rs_fetch1", 9'h081, 1, 0, 0, 1);
    step(); expect_out("rs_hold1", 9'h081, 1, 1, 0, 1);
    step(); expect_out("rs_done", 9'h000, 0, 0, 1, 1);
    bias_req = 1'b0;
    step(); expect_out("rs_idle", 9'h000, 0, 0, 0, 0);

    // Asynchronous reset in HOLD.
    cfg_base_addr = 9'h030; cfg_group_cnt = 9'd2; current_state = 3'd6;
    step(); expect_out("rst_fetch", 9'h030, 1, 0, 0, 1);
    step(); expect_out("rst_hold", 9'h030, 1, 1, 0, 1);
    #2 rstn = 1'b0;
    #1 expect_out("rst_async", 9'h000, 0, 0, 0, 0);
    current_state = 3'd0;
    @(negedge clk);
    rstn = 1'b1;
    step(); expect_out("rst_idle", 9'h000, 0, 0, 0, 0);

    // Randomized layers: random config, backpressure, aborts and back-to-back restarts.
    for (int l = 0; l < 40; l++) begin
      do r_cs = 3'($urandom_range(1, 7)); while (r_cs == current_state);
      r_base  = ($urandom_range(0, 3) == 0) ? addr_t'($urandom_range(508, 511)) : addr_t'($urandom);
      r_cnt   = $urandom_range(0, 6);
      r_abort = (r_cnt > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, r_cnt - 1)) : -1;
      push_groups(r_base, r_cnt); push_done();
      cfg_base_addr = r_base;
      cfg_group_cnt = addr_t'(r_cnt);
      current_state = r_cs;
      bias_req      = 1'($urandom_range(0, 1));
      r_cons = 0;
      r_fin  = 1'b0;
      for (int c = 0; c < 200 && !r_fin; c++) begin
        r_will = BiasMem_valid_out && bias_req;
        step();
        if (r_will) r_cons++;
        cfg_base_addr = addr_t'($urandom);
        cfg_group_cnt = addr_t'($urandom);
        if (state_rst) begin
          r_fin    = 1'b1;
          bias_req = 1'b0;
        end else if (r_abort >= 0 && r_cons == r_abort && BiasMem_valid_out) begin
          current_state = 3'd0;
          bias_req      = 1'b0;
          step();
          check("rand_abort_idle", 32'(busy), 32'd0);
          check("rand_abort_pending", 32'(sb_q.size()), 32'(r_cnt - r_cons + 1));
          sb_q.delete();
          r_fin = 1'b1;
        end else begin
          bias_req = 1'($urandom_range(0, 1));
        end
      end
      check("rand_layer_end", 32'(r_fin), 32'd1);
      repeat ($urandom_range(0, 2)) step();
    end

    bias_req = 1'b0;
    repeat (3) step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
